// File: rtl/reg_scanner_pkg.sv
// Shared constants and FSM state encoding for the register-file debug scanner.
package reg_scanner_pkg;

  localparam int ADDR_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEL  = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/reg_scanner.sv
// Walks the register file debug port (full dump or a single index) and streams
// each captured word out over a valid/ready handshake.
module reg_scanner
  import reg_scanner_pkg::*;
#(
  parameter int REG_NUM = 16,
  parameter int DATA_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  input  logic [3:0]        sel_in,
  input  logic              abort,
  output logic [3:0]        reg_sel,
  input  logic [DATA_W-1:0] regfile_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [3:0]        out_idx,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(REG_NUM - 1);

  state_e              state_q;
  logic                mode_q;
  logic [ADDR_W-1:0]   regSel_q;
  logic                outValid_q;
  logic [DATA_W-1:0]   outData_q;
  logic [ADDR_W-1:0]   outIdx_q;
  logic                outLast_q;
  logic                done_q;

  // Abort outranks everything once a scan is running, including a transfer on the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      mode_q     <= 1'b0;
      regSel_q   <= '0;
      outValid_q <= 1'b0;
      outData_q  <= '0;
      outIdx_q   <= '0;
      outLast_q  <= 1'b0;
      done_q     <= 1'b0;
    end else if (abort && (state_q != IDLE)) begin
      state_q    <= IDLE;
      outValid_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start && !abort) begin
            state_q  <= SEL;
            mode_q   <= mode;
            regSel_q <= mode ? sel_in : '0;
          end
        end
        SEL: begin
          outData_q  <= regfile_data;
          outIdx_q   <= regSel_q;
          outLast_q  <= mode_q || (regSel_q == LastIdx);
          outValid_q <= 1'b1;
          state_q    <= SEND;
        end
        SEND: begin
          if (out_ready) begin
            outValid_q <= 1'b0;
            if (outLast_q) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              regSel_q <= regSel_q + 4'd1;
              state_q  <= SEL;
            end
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign reg_sel   = regSel_q;
  assign out_valid = outValid_q;
  assign out_data  = outData_q;
  assign out_idx   = outIdx_q;
  assign out_last  = outLast_q;
  assign done      = done_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_reg_scanner.sv
// Randomised self-checking bench for reg_scanner against a word-list model of each scan.
module tb_reg_scanner;

  localparam int REG_NUM = 16;

  typedef struct packed {
    logic [3:0]  idx;
    logic [15:0] data;
    logic        last;
  } word_t;

  logic        clk;
  logic        rst;
  logic        start;
  logic        mode;
  logic [3:0]  sel_in;
  logic        abort;
  logic [3:0]  reg_sel;
  logic [15:0] regfile_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [3:0]  out_idx;
  logic        out_last;
  logic        busy;
  logic        done;

  logic [15:0] regs [REG_NUM];
  int          cycle = 0;
  int          checkCount = 0;
  int          passCount = 0;

  word_t rxQ[$];
  word_t expQ[$];
  int    doneCount, doneDiff, firstValidDiff, stableErr, exitDiff;
  bit    timedOut;

  reg_scanner #(.REG_NUM(REG_NUM), .DATA_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .sel_in(sel_in),
    .abort(abort), .reg_sel(reg_sel), .regfile_data(regfile_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last), .busy(busy), .done(done)
  );

  assign regfile_data = regs[reg_sel];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cycle <= cycle + 1;

  // A scan is just the list of words it should deliver, truncated where an abort hits.
  task automatic build_expected(input bit m, input logic [3:0] sel, input int abortIdx);
    word_t w;
    expQ.delete();
    if (m) begin
      if (int'(sel) != abortIdx) begin
        w.idx = sel; w.data = regs[sel]; w.last = 1'b1;
        expQ.push_back(w);
      end
    end else begin
      for (int i = 0; i < REG_NUM; i++) begin
        if (i == abortIdx) break;
        w.idx = 4'(i); w.data = regs[i]; w.last = (i == REG_NUM - 1);
        expQ.push_back(w);
      end
    end
  endtask

  task automatic do_scan(input bit m, input logic [3:0] sel, input int stallIdx,
                         input int abortIdx, input bit randReady, input bit pokeStart);
    int    startCycle, diff, stallCnt;
    bit    prevValid, prevXfer, prevAbort, ended;
    word_t prevWord, cur;
    rxQ.delete();
    doneCount = 0; doneDiff = -1; firstValidDiff = -1; stableErr = 0; exitDiff = -1;
    timedOut = 1'b0; prevValid = 0; prevXfer = 0; prevAbort = 0; ended = 0; stallCnt = 0;
    prevWord = '0;
    @(negedge clk);
    start = 1'b1; mode = m; sel_in = sel; out_ready = 1'b1; abort = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0; mode = 1'($urandom); sel_in = 4'($urandom);
    startCycle = cycle;
    for (int i = 0; i < 300 && !ended; i++) begin
      @(negedge clk);
      diff = cycle - startCycle;
      cur.idx = out_idx; cur.data = out_data; cur.last = out_last;
      if (prevValid && !prevXfer && !prevAbort && (!out_valid || cur !== prevWord)) stableErr++;
      if (done) begin doneCount++; doneDiff = diff; end
      if (out_valid && firstValidDiff < 0) firstValidDiff = diff;
      if (!busy) begin
        ended = 1; exitDiff = diff;
        start = 1'b0; abort = 1'b0; out_ready = 1'b1;
      end else begin
        if (out_valid && int'(out_idx) == stallIdx && stallCnt < 5) begin
          out_ready = 1'b0; stallCnt++;
        end else begin
          out_ready = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        abort = out_valid && (abortIdx >= 0) && (int'(out_idx) == abortIdx);
        if (pokeStart) start = 1'($urandom_range(0, 1));
        prevXfer = out_valid && out_ready && !abort;
        prevAbort = abort;
        if (prevXfer) rxQ.push_back(cur);
      end
      prevValid = out_valid;
      prevWord = cur;
    end
    if (!ended) timedOut = 1'b1;
    start = 1'b0; abort = 1'b0; out_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; mode = 1'b0; sel_in = '0; abort = 1'b0; out_ready = 1'b1;
    #2;
    checkCount++;
    if ({reg_sel, out_valid, out_data, out_idx, out_last, busy, done} !== '0) begin
      $display("[TB] FAIL reset_outputs got %h expected 0",
               {reg_sel, out_valid, out_data, out_idx, out_last, busy, done});
    end else passCount++;
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    checkCount++;
    if (busy !== 1'b0) $display("[TB] FAIL reset_idle busy got %b expected 0", busy);
    else passCount++;
  endtask

  task automatic test_full_dump();
    for (int i = 0; i < REG_NUM; i++) regs[i] = 16'h1000 + 16'(i);
    build_expected(0, 4'h0, -1);
    do_scan(0, 4'h0, -1, -1, 0, 0);
    checkCount++;
    if (rxQ.size() != expQ.size()) $display("[TB] FAIL full_count got %0d expected %0d", rxQ.size(), expQ.size());
    else passCount++;
    for (int i = 0; i < expQ.size() && i < rxQ.size(); i++) begin
      checkCount++;
      if (rxQ[i] !== expQ[i]) $display("[TB] FAIL full_word%0d got %h expected %h", i, rxQ[i], expQ[i]);
      else passCount++;
    end
    checkCount++;
    if (firstValidDiff != 1) $display("[TB] FAIL full_first_valid got %0d expected 1", firstValidDiff);
    else passCount++;
    checkCount++;
    if (doneCount != 1 || doneDiff != 2 * REG_NUM)
      $display("[TB] FAIL full_done got count %0d at %0d expected 1 at %0d", doneCount, doneDiff, 2 * REG_NUM);
    else passCount++;
  endtask

  task automatic test_single();
    for (int i = 0; i < REG_NUM; i++) regs[i] = 16'($urandom);
    regs[10] = 16'hBEEF;
    build_expected(1, 4'hA, -1);
    do_scan(1, 4'hA, -1, -1, 0, 0);
    checkCount++;
    if (rxQ.size() != 1 || rxQ[0] !== expQ[0])
      $display("[TB] FAIL single_word got %0d words first %h expected 1 word %h",
               rxQ.size(), (rxQ.size() > 0) ? rxQ[0] : '0, expQ[0]);
    else passCount++;
    checkCount++;
    if (doneCount != 1 || doneDiff != 2)
      $display("[TB] FAIL single_done got count %0d at %0d expected 1 at 2", doneCount, doneDiff);
    else passCount++;
  endtask

  task automatic test_stall();
    for (int i = 0; i < REG_NUM; i++) regs[i] = 16'($urandom);
    build_expected(0, 4'h0, -1);
    do_scan(0, 4'h0, 3, -1, 0, 0);
    checkCount++;
    if (stableErr != 0) $display("[TB] FAIL stall_stable got %0d changes expected 0", stableErr);
    else passCount++;
    checkCount++;
    if (rxQ != expQ || timedOut) $display("[TB] FAIL stall_words got %0d words expected %0d", rxQ.size(), expQ.size());
    else passCount++;
    checkCount++;
    if (doneCount != 1 || doneDiff != 2 * REG_NUM + 5)
      $display("[TB] FAIL stall_done got count %0d at %0d expected 1 at %0d", doneCount, doneDiff, 2 * REG_NUM + 5);
    else passCount++;
  endtask

  task automatic test_abort();
    for (int i = 0; i < REG_NUM; i++) regs[i] = 16'($urandom);
    build_expected(0, 4'h0, 7);
    do_scan(0, 4'h0, -1, 7, 0, 0);
    checkCount++;
    if (rxQ != expQ) $display("[TB] FAIL abort_words got %0d words expected %0d", rxQ.size(), expQ.size());
    else passCount++;
    checkCount++;
    if (doneCount != 0) $display("[TB] FAIL abort_no_done got %0d expected 0", doneCount);
    else passCount++;
    checkCount++;
    if (exitDiff != 16 || out_valid !== 1'b0)
      $display("[TB] FAIL abort_idle got exit %0d valid %b expected 16 and 0", exitDiff, out_valid);
    else passCount++;
    @(negedge clk); start = 1'b1; abort = 1'b1;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    checkCount++;
    if (busy !== 1'b0) $display("[TB] FAIL abort_start_idle busy got %b expected 0", busy);
    else passCount++;
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < REG_NUM; i++) regs[i] = 16'h1000 + 16'(i);
    @(negedge clk); start = 1'b1; mode = 1'b0; out_ready = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (8) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    checkCount++;
    if ({reg_sel, out_valid, out_data, out_idx, out_last, busy, done} !== '0) begin
      $display("[TB] FAIL async_reset got %h expected 0",
               {reg_sel, out_valid, out_data, out_idx, out_last, busy, done});
    end else passCount++;
    @(negedge clk); rst = 1'b1;
    repeat (3) @(negedge clk);
    checkCount++;
    if (busy !== 1'b0 || out_valid !== 1'b0) $display("[TB] FAIL reset_wait busy %b valid %b expected 0 0", busy, out_valid);
    else passCount++;
    build_expected(0, 4'h0, -1);
    do_scan(0, 4'h0, -1, -1, 0, 0);
    checkCount++;
    if (rxQ != expQ || doneCount != 1)
      $display("[TB] FAIL reset_restart got %0d words done %0d expected %0d words done 1", rxQ.size(), doneCount, expQ.size());
    else passCount++;
  endtask

  task automatic test_back_to_back();
    logic [3:0] s;
    for (int k = 0; k < 2; k++) begin
      s = 4'($urandom);
      for (int i = 0; i < REG_NUM; i++) regs[i] = 16'($urandom);
      build_expected(1'(k), s, -1);
      do_scan(1'(k), s, -1, -1, 0, 1);
      checkCount++;
      if (rxQ != expQ || doneCount != 1)
        $display("[TB] FAIL b2b_mode%0d got %0d words done %0d expected %0d words done 1", k, rxQ.size(), doneCount, expQ.size());
      else passCount++;
    end
  endtask

  task automatic test_random();
    bit m;
    logic [3:0] s;
    for (int k = 0; k < 6; k++) begin
      m = 1'($urandom);
      s = 4'($urandom);
      for (int i = 0; i < REG_NUM; i++) regs[i] = 16'($urandom);
      build_expected(m, s, -1);
      do_scan(m, s, -1, -1, 1, 0);
      checkCount++;
      if (rxQ != expQ || doneCount != 1 || stableErr != 0 || timedOut)
        $display("[TB] FAIL random%0d got %0d words done %0d unstable %0d expected %0d words done 1 unstable 0",
                 k, rxQ.size(), doneCount, stableErr, expQ.size());
      else passCount++;
    end
  endtask

  initial begin
    test_reset();
    test_full_dump();
    test_single();
    test_stall();
    test_abort();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog");
  end

endmodule
